uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Parameters
REQ-001 DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 CLKS_PER_BIT, default 16, clk_s cycles each line bit is held; legal range 1..65535.
REQ-003 PARITY, default 0, parity mode: 0 none, 1 odd, 2 even; 3 is illegal.
REQ-004 STOP_BITS, default 1, number of stop bits; legal values 1 or 2.

Interface
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk_s  input  1  system clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 send  input  1  transmit request; sampled only in IDLE.
REQ-009 data_in  input  DATA_BITS  frame payload; captured on acceptance.
REQ-010 busy  output  1  high while a frame is in progress.
REQ-011 tx  output  1  serial line; idle level 1.
REQ-012 done  output  1  single-cycle pulse at frame completion.
REQ-013 led_tx  output  1  activity indicator; equals busy.

Function
REQ-014 FSM states: IDLE, START, DATA, PAR, STOP; all outputs registered.
REQ-015 Acceptance: in IDLE with send=1, capture data_in into a shift register and go to START; busy=1 and tx=0 from the next cycle (1-cycle latency).
REQ-016 Each line bit (start, every data bit, parity, every stop bit) is held exactly CLKS_PER_BIT cycles, timed by a 16-bit baud counter that reloads at each bit boundary.
REQ-017 START: tx=0 for one bit time, then DATA.
REQ-018 DATA: DATA_BITS bits sent LSB first from the captured value; a bit index counter tracks progress; after the last bit go to PAR if PARITY!=0, otherwise to STOP.
REQ-019 PAR: tx = XOR of the captured bits for even parity, or its complement for odd parity; held one bit time, then STOP.
REQ-020 STOP: tx=1 for STOP_BITS bit times; on the last cycle go to IDLE, busy=0, done=1 for exactly one cycle.
REQ-021 Frame length from first start cycle to busy falling: (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-022 Changes on data_in after acceptance have no effect on the frame in progress.
REQ-023 send while busy=1 is ignored; it is not queued.
REQ-024 send held high continuously: the next frame is accepted in the IDLE cycle that follows done, giving exactly one idle cycle of tx=1 between frames.
REQ-025 tx=1 in every IDLE cycle.
REQ-026 Illegal parameter values are rejected at elaboration by a synthesis-time check.

Reset
REQ-027 rst=1 immediately forces state=IDLE, tx=1, busy=0, done=0, led_tx=0, and clears the baud counter, bit index and shift register, regardless of clock.
REQ-028 rst asserted mid-frame aborts the frame with no done pulse; the first accept after rst releases starts a clean frame.

Verification
REQ-029 DATA_BITS=8, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy high 40 cycles; one done pulse.
REQ-030 Same configuration with PARITY=2; send 0xA5 -> parity bit 0, busy high 44 cycles; with PARITY=1 -> parity bit 1.
REQ-031 DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=1; send 0x7F -> tx = 0,1,1,1,1,1,1,1,1,1; busy high 10 cycles.
REQ-032 data_in changed from 0xA5 to 0x00 two cycles after acceptance, and send pulsed mid-frame -> transmitted frame still carries 0xA5; no second frame starts.
REQ-033 send held high for 3 frames -> three identical back-to-back frames, each separated by exactly one tx=1 idle cycle; three done pulses.
REQ-034 rst pulsed during data bit 3 -> tx=1 and busy=0 asynchronously; no done pulse; the next send yields a correct full frame.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, 5..9 data bits sent LSB first,
// optional odd/even parity bit and 1 or 2 stop bits.
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_s,
  input  logic                 rst,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 busy,
  output logic                 tx,
  output logic                 done,
  output logic                 led_tx
);

  // state | meaning
  // IDLE  | line at 1, waiting for send
  // START | start bit (tx=0)
  // DATA  | payload bits, LSB first
  // PAR   | parity bit (only when PARITY != 0)
  // STOP  | stop bit(s), tx=1; done pulses on exit

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("uart_tx_param: CLKS_PER_BIT must be in 1..65535");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_DATA   = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STOP   = 4'(STOP_BITS - 1);
  localparam logic        PAR_INV     = (PARITY == 1);

  state_t               state;
  logic [15:0]          baud_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  assign led_tx = busy;

  // tx is registered, so each bit boundary loads the value of the next bit.
  always_ff @(posedge clk_s or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (send) begin
            shreg    <= data_in;
            par_bit  <= (^data_in) ^ PAR_INV;
            baud_cnt <= BAUD_RELOAD;
            bit_idx  <= '0;
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (baud_cnt == 16'd0) begin
            baud_cnt <= BAUD_RELOAD;
            state    <= DATA;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (baud_cnt == 16'd0) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                state <= PAR;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        PAR: begin
          if (baud_cnt == 16'd0) begin
            baud_cnt <= BAUD_RELOAD;
            state    <= STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        STOP: begin
          if (baud_cnt == 16'd0) begin
            if (bit_idx == LAST_STOP) begin
              state   <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              bit_idx <= '0;
            end else begin
              bit_idx  <= bit_idx + 4'd1;
              baud_cnt <= BAUD_RELOAD;
            end
            tx <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four parameter sets, directed vectors, random frames
// against a frame-building model, and multi-cycle corner sequences.
module tb_uart_tx_param;

  logic       clk;
  logic       rst;
  logic       send_v [4];
  logic [8:0] data_v [4];
  logic       busy_v [4];
  logic       tx_v   [4];
  logic       done_v [4];
  logic       led_v  [4];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk_s(clk), .rst(rst), .send(send_v[0]), .data_in(data_v[0][7:0]),
    .busy(busy_v[0]), .tx(tx_v[0]), .done(done_v[0]), .led_tx(led_v[0]));
  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_dut1 (
    .clk_s(clk), .rst(rst), .send(send_v[1]), .data_in(data_v[1][7:0]),
    .busy(busy_v[1]), .tx(tx_v[1]), .done(done_v[1]), .led_tx(led_v[1]));
  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_dut2 (
    .clk_s(clk), .rst(rst), .send(send_v[2]), .data_in(data_v[2][7:0]),
    .busy(busy_v[2]), .tx(tx_v[2]), .done(done_v[2]), .led_tx(led_v[2]));
  uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(2)) u_dut3 (
    .clk_s(clk), .rst(rst), .send(send_v[3]), .data_in(data_v[3][6:0]),
    .busy(busy_v[3]), .tx(tx_v[3]), .done(done_v[3]), .led_tx(led_v[3]));

  function automatic int cfg_db(input int k);
    return (k == 3) ? 7 : 8;
  endfunction
  function automatic int cfg_cpb(input int k);
    return (k == 3) ? 1 : 4;
  endfunction
  function automatic int cfg_par(input int k);
    return (k == 1) ? 2 : (k == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_stop(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  // Expected line bits in time order (bit 0 = start bit) and the bit count.
  function automatic logic [15:0] model_line(input int k, input logic [8:0] d, output int len);
    logic [15:0] l;
    int ones;
    int pos;
    l = '0;
    ones = 0;
    pos = 1;
    for (int i = 0; i < cfg_db(k); i++) begin
      l[pos] = d[i];
      ones += int'(d[i]);
      pos++;
    end
    if (cfg_par(k) == 2) begin
      l[pos] = 1'(ones % 2);
      pos++;
    end else if (cfg_par(k) == 1) begin
      l[pos] = 1'(1 - (ones % 2));
      pos++;
    end
    for (int s = 0; s < cfg_stop(k); s++) begin
      l[pos] = 1'b1;
      pos++;
    end
    len = pos;
    return l;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue a one-cycle send; checks the one-cycle acceptance latency.
  task automatic send_frame(input int k, input logic [8:0] d);
    @(negedge clk);
    data_v[k] = d;
    send_v[k] = 1'b1;
    @(negedge clk);
    send_v[k] = 1'b0;
    check("accept_busy", 32'(busy_v[k]), 32'd1);
    check("accept_tx", 32'(tx_v[k]), 32'd0);
  endtask

  // Called on the first busy cycle; records the line until busy falls and
  // returns on the first idle cycle.
  task automatic observe(input int k, output logic [15:0] line, output int bcyc,
                         output int dcnt, output bit stable);
    bit samp[$];
    int cpb;
    cpb = cfg_cpb(k);
    line = '0;
    bcyc = 0;
    dcnt = 0;
    stable = 1'b1;
    while (busy_v[k] === 1'b1 && bcyc < 2000) begin
      samp.push_back(tx_v[k]);
      if (led_v[k] !== 1'b1) stable = 1'b0;
      if (done_v[k] === 1'b1) dcnt++;
      bcyc++;
      @(negedge clk);
    end
    if (done_v[k] === 1'b1) dcnt++;
    if (tx_v[k] !== 1'b1 || led_v[k] !== 1'b0) stable = 1'b0;
    for (int j = 0; j < samp.size() / cpb && j < 16; j++) begin
      line[j] = samp[j * cpb];
      for (int c = 1; c < cpb; c++)
        if (samp[j * cpb + c] != samp[j * cpb]) stable = 1'b0;
    end
  endtask

  typedef struct {
    int          dut;
    logic [8:0]  data;
    logic [15:0] exp_line;
    int          exp_busy;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] line, mline;
    int bcyc, dcnt, len, cnt, k;
    bit stable;
    logic [8:0] d;

    vecs[0] = '{0, 9'h0A5, 16'h034A, 40};
    vecs[1] = '{1, 9'h0A5, 16'h054A, 44};
    vecs[2] = '{2, 9'h0A5, 16'h074A, 44};
    vecs[3] = '{3, 9'h07F, 16'h03FE, 10};

    for (int i = 0; i < 4; i++) begin
      send_v[i] = 1'b0;
      data_v[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("reset_tx", 32'(tx_v[i]), 32'd1);
      check("reset_busy", 32'(busy_v[i]), 32'd0);
      check("reset_done", 32'(done_v[i]), 32'd0);
      check("reset_led", 32'(led_v[i]), 32'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].dut, vecs[i].data);
      observe(vecs[i].dut, line, bcyc, dcnt, stable);
      check("vec_line", 32'(line), 32'(vecs[i].exp_line));
      check("vec_busy_cycles", 32'(bcyc), 32'(vecs[i].exp_busy));
      check("vec_done_count", 32'(dcnt), 32'd1);
      check("vec_stable", 32'(stable), 32'd1);
      @(negedge clk);
      check("vec_done_single", 32'(done_v[vecs[i].dut]), 32'd0);
    end

    for (int r = 0; r < 24; r++) begin
      k = int'($urandom_range(0, 3));
      d = 9'($urandom) & 9'((1 << cfg_db(k)) - 1);
      mline = model_line(k, d, len);
      send_frame(k, d);
      observe(k, line, bcyc, dcnt, stable);
      check("rand_line", 32'(line), 32'(mline));
      check("rand_busy_cycles", 32'(bcyc), 32'(len * cfg_cpb(k)));
      check("rand_done_count", 32'(dcnt), 32'd1);
      check("rand_stable", 32'(stable), 32'd1);
      @(negedge clk);
    end

    // data_in change and send pulse while a frame is in flight
    mline = model_line(0, 9'h0A5, len);
    send_frame(0, 9'h0A5);
    fork
      observe(0, line, bcyc, dcnt, stable);
      begin
        repeat (2) @(negedge clk);
        data_v[0] = 9'h000;
        repeat (10) @(negedge clk);
        send_v[0] = 1'b1;
        @(negedge clk);
        send_v[0] = 1'b0;
      end
    join
    check("hold_line", 32'(line), 32'(mline));
    check("hold_busy_cycles", 32'(bcyc), 32'd40);
    check("hold_done_count", 32'(dcnt), 32'd1);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy_v[0] !== 1'b0) cnt++;
    end
    check("no_queued_frame", 32'(cnt), 32'd0);

    // send held high: three back-to-back frames, one idle cycle apart
    mline = model_line(0, 9'h03C, len);
    @(negedge clk);
    data_v[0] = 9'h03C;
    send_v[0] = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      check("b2b_start", 32'(busy_v[0]), 32'd1);
      if (f == 2) send_v[0] = 1'b0;
      observe(0, line, bcyc, dcnt, stable);
      check("b2b_line", 32'(line), 32'(mline));
      check("b2b_busy_cycles", 32'(bcyc), 32'd40);
      check("b2b_done", 32'(dcnt), 32'd1);
      check("b2b_idle_tx", 32'(tx_v[0]), 32'd1);
      @(negedge clk);
    end
    check("b2b_stops", 32'(busy_v[0]), 32'd0);

    // asynchronous reset during data bit 3
    send_frame(0, 9'h0A5);
    repeat (17) @(negedge clk);
    check("abort_busy_before", 32'(busy_v[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_tx_async", 32'(tx_v[0]), 32'd1);
    check("abort_busy_async", 32'(busy_v[0]), 32'd0);
    check("abort_led_async", 32'(led_v[0]), 32'd0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_v[0] !== 1'b0) cnt++;
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) cnt++;
    end
    check("abort_no_done", 32'(cnt), 32'd0);
    mline = model_line(0, 9'h05A, len);
    send_frame(0, 9'h05A);
    observe(0, line, bcyc, dcnt, stable);
    check("after_reset_line", 32'(line), 32'(mline));
    check("after_reset_busy", 32'(bcyc), 32'd40);
    check("after_reset_done", 32'(dcnt), 32'd1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
